skid_buffer: RTL
================

Name: skid_buffer

Overview:
- Two-entry elastic pipeline stage with valid/ready handshake on both sides.
- Sits between a producing datapath stage and a consuming one, for example in front of a stage holding register or a register-file write port.
- Decouples the back-pressure path: in_ready is driven only from flops, so there is no combinational path from out_ready to in_ready.
- Sustains one transfer per cycle with 1-cycle latency.

Parameters:
DATA_WIDTH, 32, payload width in bits

Ports:
clk  input  1  clock, rising edge
rstn  input  1  asynchronous reset, active-low
flush  input  1  synchronous clear of all buffered entries
in_valid  input  1  upstream presents valid data
in_data  input  DATA_WIDTH  upstream payload
in_ready  output  1  buffer can accept this cycle (registered)
out_valid  output  1  out_data holds a valid entry (registered)
out_data  output  DATA_WIDTH  head-of-buffer payload (registered)
out_ready  input  1  downstream accepts this cycle
occupancy  output  2  entries held: 0, 1 or 2

Behaviour:
- Reset is rstn, asynchronous, active-low; clock is clk.
- Reset values:
  - state EMPTY, out_valid=0, in_ready=1, occupancy=0.
  - out_data=0, skid register=0.
- Handshakes:
  - Input fire = in_valid & in_ready.
  - Output fire = out_valid & out_ready.
  - in_valid may assert independently of in_ready.
- States are derived from occupancy:
  - EMPTY (occupancy 0): out_valid=0, in_ready=1.
  - BUSY (occupancy 1): out_valid=1, in_ready=1.
  - FULL (occupancy 2): out_valid=1, in_ready=0.
- Transitions (flush=0):
  - EMPTY, in fire: out_data<=in_data; go to BUSY. The data is visible on the next cycle (latency 1).
  - EMPTY, no fire: hold.
  - BUSY, in fire and out fire: out_data<=in_data; stay BUSY. This is full-throughput streaming.
  - BUSY, in fire only: skid<=in_data; go to FULL.
  - BUSY, out fire only: go to EMPTY. out_data holds its stale value.
  - BUSY, no fire: hold.
  - FULL, out fire: out_data<=skid; go to BUSY. No input can fire because in_ready=0.
  - FULL, no fire: hold.
- Ordering: strict FIFO. The skid entry is always younger than the out_data entry.
- Stability: while out_valid=1 and out_ready=0, out_data must not change.
- Flush:
  - Synchronous; highest priority over every handshake.
  - Next state is EMPTY, occupancy 0.
  - An input offered in the flush cycle is dropped, even if in_ready=1.
  - An output fire in the flush cycle counts as delivered.
  - Data registers are not cleared.
- Reset mid-operation: rstn low immediately forces the reset values and discards every entry. The first accept after rstn rises happens no earlier than the first clock edge following release.
- in_ready, out_valid and occupancy are pure flop outputs with no combinational input dependence.
- Data registers are enabled registers, written only on the load conditions above. Width is DATA_WIDTH throughout; no arithmetic on the payload.

Decomposition:
- Shared package:
  - State encoding localparams (EMPTY=2'd0, BUSY=2'd1, FULL=2'd2), also used directly as the occupancy value.
  - Default DATA_WIDTH constant.
- No sub-module required. The two payload holding registers are plain enabled registers and may be instantiated from the existing enabled-register primitive with DATA_WIDTH passed through.

Test Plan:
1. Reset, then idle with in_valid=0: out_valid=0, in_ready=1, occupancy=0, out_data=0. Pulse rstn low mid-FULL: all three return to reset values without waiting for a clock edge.
2. Stream 0x11..0x18 with out_ready=1 held: out_data shows 0x11 one cycle after first accept, then one word per cycle in order; occupancy stays 1; in_ready never drops.
3. Send 0xA, 0xB, 0xC back-to-back with out_ready=0: 0xA and 0xB are accepted, occupancy=2, in_ready=0, and 0xC is held upstream. Raise out_ready: output sequence is 0xA, 0xB, 0xC with no loss or duplication.
4. Random in_valid/out_ready at 50% each for 10k cycles against a scoreboard model: order preserved, out_data stable while stalled, occupancy always ≤2.
5. FULL with 0x5,0x6, assert flush with in_valid=1 carrying 0x7 and out_ready=1: 0x5 is counted delivered, 0x6 and 0x7 are dropped, next cycle occupancy=0, out_valid=0, in_ready=1.
6. Combinational check: toggle out_ready with state held between edges: in_ready does not change within the cycle.

Source files
------------

// File: rtl/skid_buffer_pkg.sv
// -----------------------------------------------------------------------------
// skid_buffer_pkg
//   Shared definitions for the two-entry skid buffer.
//   - DEFAULT_DATA_WIDTH : default payload width in bits.
//   - EMPTY / BUSY / FULL : state encodings. Each value equals the number of
//     entries held, so the state register is also the occupancy count.
//   - state_e             : FSM state type built from those encodings.
//   - state_to_occ()      : maps a state to the 2-bit occupancy output.
// -----------------------------------------------------------------------------
package skid_buffer_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] BUSY  = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  typedef enum logic [1:0] {
    ST_EMPTY = EMPTY,
    ST_BUSY  = BUSY,
    ST_FULL  = FULL
  } state_e;

  // The encoding was chosen so this is a plain re-typing, not a decode.
  function automatic logic [1:0] state_to_occ(input state_e s);
    return s;
  endfunction

endpackage

// File: rtl/skid_buffer_en_reg.sv
// -----------------------------------------------------------------------------
// skid_buffer_en_reg
//   Enabled payload register. It loads d on a rising clk edge when en is high
//   and otherwise holds its value. The asynchronous reset clears it to zero.
//   Ports:
//     clk  - clock, rising edge
//     rstn - asynchronous reset, active-low
//     en   - load enable
//     d    - WIDTH-bit load value
//     q    - WIDTH-bit registered value
// -----------------------------------------------------------------------------
module skid_buffer_en_reg
  import skid_buffer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (en) begin
      q_d = d;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/skid_buffer.sv
// -----------------------------------------------------------------------------
// skid_buffer
//   Two-entry elastic pipeline stage with a valid/ready handshake on both
//   sides. in_ready, out_valid and occupancy come straight from flops, so
//   out_ready has no combinational path to in_ready. The stage sustains one
//   transfer per cycle with one cycle of latency.
//
//   Entries are kept in strict FIFO order. The head register drives out_data.
//   The skid register holds the younger entry, which is accepted while the
//   head is stalled.
//
//   Ports:
//     clk       - clock, rising edge
//     rstn      - asynchronous reset, active-low
//     flush     - synchronous clear of all buffered entries (top priority)
//     in_valid  - upstream presents valid data
//     in_data   - upstream payload
//     in_ready  - buffer can accept this cycle (registered)
//     out_valid - out_data holds a valid entry (registered)
//     out_data  - head-of-buffer payload (registered)
//     out_ready - downstream accepts this cycle
//     occupancy - number of entries held: 0, 1 or 2
// -----------------------------------------------------------------------------
module skid_buffer
  import skid_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic [1:0]            occupancy
);

  state_e state_q;
  state_e state_d;
  logic   in_ready_q;
  logic   in_ready_d;
  logic   out_valid_q;
  logic   out_valid_d;

  logic   in_fire;
  logic   out_fire;

  logic   head_load;
  logic   head_from_skid;
  logic   skid_load;

  logic [DATA_WIDTH-1:0] head_d;
  logic [DATA_WIDTH-1:0] head_q;
  logic [DATA_WIDTH-1:0] skid_q;

  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = out_valid_q & out_ready;

  // Next-state and load-enable decode. Flush overrides every handshake:
  // the entries are discarded and neither data register is written. An
  // output that fires in the same cycle still counts as delivered.
  always_comb begin
    state_d        = state_q;
    head_load      = 1'b0;
    head_from_skid = 1'b0;
    skid_load      = 1'b0;

    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            head_load = 1'b1;
            state_d   = ST_BUSY;
          end
        end

        ST_BUSY: begin
          case ({in_fire, out_fire})
            2'b11: begin
              // Streaming case: the head is replaced by the new word.
              head_load = 1'b1;
            end
            2'b10: begin
              // The head is stalled, so the new word parks behind it.
              skid_load = 1'b1;
              state_d   = ST_FULL;
            end
            2'b01: begin
              // The head leaves. out_data keeps its stale value, which is
              // harmless because out_valid drops.
              state_d = ST_EMPTY;
            end
            default: begin
              state_d = state_q;
            end
          endcase
        end

        ST_FULL: begin
          // in_ready is low here, so only the output side can move.
          if (out_fire) begin
            head_load      = 1'b1;
            head_from_skid = 1'b1;
            state_d        = ST_BUSY;
          end
        end

        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  // The handshake flags are computed from the next state so that each one
  // can be registered alongside the state itself.
  always_comb begin
    in_ready_d  = (state_d != ST_FULL);
    out_valid_d = (state_d != ST_EMPTY);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign head_d = head_from_skid ? skid_q : in_data;

  skid_buffer_en_reg #(
    .WIDTH (DATA_WIDTH)
  ) u_head_reg (
    .clk  (clk),
    .rstn (rstn),
    .en   (head_load),
    .d    (head_d),
    .q    (head_q)
  );

  skid_buffer_en_reg #(
    .WIDTH (DATA_WIDTH)
  ) u_skid_reg (
    .clk  (clk),
    .rstn (rstn),
    .en   (skid_load),
    .d    (in_data),
    .q    (skid_q)
  );

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = head_q;
  assign occupancy = state_to_occ(state_q);

endmodule
